// File: rtl/dvi_tx_pkg.sv
// dvi_tx_pkg: constants shared across the DVI transmitter video path
// Contents: counter width/type, colour-bar palette and lookup, TMDS control-token bit indices.
package dvi_tx_pkg;
   localparam int CNT_W = 12;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [23:0] rgb_t;
   typedef enum logic [2:0] {
      BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN, BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
   } bar_e;
   localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
   localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
   localparam rgb_t RGB_CYAN    = 24'h00FFFF;
   localparam rgb_t RGB_GREEN   = 24'h00FF00;
   localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
   localparam rgb_t RGB_RED     = 24'hFF0000;
   localparam rgb_t RGB_BLUE    = 24'h0000FF;
   localparam rgb_t RGB_BLACK   = 24'h000000;
   // Element 0 is the leftmost bar.
   localparam logic [7:0][23:0] BAR_LUT = {RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
                                           RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE};
   // Bit positions of the control pair carried by the blue encoder.
   localparam int CTRL_HSYNC = 0;
   localparam int CTRL_VSYNC = 1;
   function automatic rgb_t bar_colour(input bar_e idx);
      return BAR_LUT[idx];
   endfunction
endpackage

// File: rtl/dvi_tx_video_timing_if.sv
// dvi_tx_video_timing_if: pixel-source handshake and encoder-side video bundle
// master: timing generator (drives pix_req and video outputs, receives pix_data/pattern_en)
// slave : pixel source / encoder side.
// pattern_en exists only with DVI_TX_TEST_PATTERN_EN.
interface dvi_tx_video_timing_if;
   import dvi_tx_pkg::*;
   logic       pix_req;
   logic [23:0] pix_data;
   logic       den;
   logic [1:0] ctrl_b;
   logic [7:0] data_r;
   logic [7:0] data_g;
   logic [7:0] data_b;
   cnt_t       h_pos;
   cnt_t       v_pos;
   logic       frame_start;
`ifdef DVI_TX_TEST_PATTERN_EN
   logic       pattern_en;
   modport master (input pix_data, pattern_en,
                   output pix_req, den, ctrl_b, data_r, data_g, data_b, h_pos, v_pos, frame_start);
   modport slave (output pix_data, pattern_en,
                  input pix_req, den, ctrl_b, data_r, data_g, data_b, h_pos, v_pos, frame_start);
`else
   modport master (input pix_data,
                   output pix_req, den, ctrl_b, data_r, data_g, data_b, h_pos, v_pos, frame_start);
   modport slave (output pix_data,
                  input pix_req, den, ctrl_b, data_r, data_g, data_b, h_pos, v_pos, frame_start);
`endif
endinterface

// File: rtl/dvi_tx_bar_gen.sv
// dvi_tx_bar_gen: eight-bar colour generator, output aligned one cycle after the counter
// Ports: clock, reset_n (async active low), i_enable (low clears), i_h_cnt (horizontal
//   counter), o_rgb (colour of the pixel whose counter value was seen on the previous edge).
// Bar index advances from a bar-width counter, so no divider is needed.
module dvi_tx_bar_gen
   import dvi_tx_pkg::*;
#(
   parameter int H_ACTIVE = 640
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_enable,
   input  cnt_t i_h_cnt,
   output rgb_t o_rgb
);
   localparam cnt_t BAR_LAST = cnt_t'(H_ACTIVE / 8 - 1);
   cnt_t r_cnt;
   bar_e r_idx;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_cnt <= '0;
         r_idx <= BAR_WHITE;
      end else if (!i_enable || i_h_cnt == '0) begin
         r_cnt <= '0;
         r_idx <= BAR_WHITE;
      end else if (r_cnt == BAR_LAST) begin
         r_cnt <= '0;
         r_idx <= bar_e'(r_idx + 3'd1);
      end else
         r_cnt <= r_cnt + cnt_t'(1);
   assign o_rgb = bar_colour(r_idx);
endmodule

// File: rtl/dvi_tx_video_timing.sv
// dvi_tx_video_timing: video timing generator and pixel front end for the TMDS encoders
// Ports: clock (pixel clock), reset_n (async active low), enable (low holds idle),
//   vif (master): pix_req/pix_data request-ahead source; den, ctrl_b={vsync,hsync},
//   data_r/g/b, h_pos, v_pos, frame_start registered two cycles behind the counters.
// Macro DVI_TX_TEST_PATTERN_EN adds pattern_en and a colour-bar source chosen per frame.
module dvi_tx_video_timing
   import dvi_tx_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input logic clock,
   input logic reset_n,
   input logic enable,
   dvi_tx_video_timing_if.master vif
);
   localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
   localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t H_LAST = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
   localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
   localparam cnt_t V_LAST = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   if (H_ACTIVE % 8 != 0) begin : g_bad_h_active
      $error("H_ACTIVE must be a multiple of 8");
   end
   if (H_ACTIVE + H_FP + H_SYNC + H_BP > 4095 || V_ACTIVE + V_FP + V_SYNC + V_BP > 4095)
   begin : g_bad_totals
      $error("timing totals exceed the 12-bit counter range");
   end
   cnt_t r_h_cnt, r_v_cnt, r_h1, r_v1, r_h2, r_v2;
   logic r_den1, r_hs1, r_vs1, r_fs1, r_den2, r_hs2, r_vs2, r_fs2;
   rgb_t r_rgb2, w_src;
   logic w_h_last, w_v_last, w_active, w_hs_on, w_vs_on, w_fs, w_pix_req;
   logic [1:0] w_ctrl;
   assign w_h_last = r_h_cnt == H_LAST;
   assign w_v_last = r_v_cnt == V_LAST;
   assign w_active = r_h_cnt < H_ACT && r_v_cnt < V_ACT;
   assign w_hs_on  = r_h_cnt >= HS_BEG && r_h_cnt < HS_END;
   assign w_vs_on  = r_v_cnt >= VS_BEG && r_v_cnt < VS_END;
   assign w_fs     = r_h_cnt == '0 && r_v_cnt == '0;
   // S0: free-running counters, cleared whenever enable is low so a restart begins at (0,0).
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (!enable) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else begin
         r_h_cnt <= w_h_last ? '0 : r_h_cnt + cnt_t'(1);
         if (w_h_last) r_v_cnt <= w_v_last ? '0 : r_v_cnt + cnt_t'(1);
      end
`ifdef DVI_TX_TEST_PATTERN_EN
   logic r_pat_sel, r_pat1, w_pat_sel;
   rgb_t w_bar;
   // The source choice for pixel (0,0) must already follow pattern_en, so bypass the register there.
   assign w_pat_sel = w_fs ? vif.pattern_en : r_pat_sel;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_pat_sel <= 1'b0;
         r_pat1    <= 1'b0;
      end else begin
         if (enable && w_fs) r_pat_sel <= vif.pattern_en;
         r_pat1 <= enable & w_pat_sel;
      end
   dvi_tx_bar_gen #(.H_ACTIVE(H_ACTIVE)) u_bar_gen (
      .clock   (clock),
      .reset_n (reset_n),
      .i_enable(enable),
      .i_h_cnt (r_h_cnt),
      .o_rgb   (w_bar)
   );
   assign w_src     = r_pat1 ? w_bar : vif.pix_data;
   assign w_pix_req = reset_n & enable & w_active & ~w_pat_sel;
`else
   assign w_src     = vif.pix_data;
   assign w_pix_req = reset_n & enable & w_active;
`endif
   // S1: registered decode; upstream presents pix_data during this stage.
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_den1 <= 1'b0;
         r_hs1  <= ~HS_POL;
         r_vs1  <= ~VS_POL;
         r_fs1  <= 1'b0;
         r_h1   <= '0;
         r_v1   <= '0;
      end else begin
         r_den1 <= enable & w_active;
         r_hs1  <= (enable & w_hs_on) ? HS_POL : ~HS_POL;
         r_vs1  <= (enable & w_vs_on) ? VS_POL : ~VS_POL;
         r_fs1  <= enable & w_fs;
         r_h1   <= enable ? r_h_cnt : '0;
         r_v1   <= enable ? r_v_cnt : '0;
      end
   // S2: output registers; pixel data is captured here and blanked outside the active region.
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_den2 <= 1'b0;
         r_hs2  <= ~HS_POL;
         r_vs2  <= ~VS_POL;
         r_fs2  <= 1'b0;
         r_h2   <= '0;
         r_v2   <= '0;
         r_rgb2 <= '0;
      end else begin
         r_den2 <= enable & r_den1;
         r_hs2  <= enable ? r_hs1 : ~HS_POL;
         r_vs2  <= enable ? r_vs1 : ~VS_POL;
         r_fs2  <= enable & r_fs1;
         r_h2   <= enable ? r_h1 : '0;
         r_v2   <= enable ? r_v1 : '0;
         r_rgb2 <= (enable & r_den1) ? w_src : '0;
      end
   always_comb begin
      w_ctrl = '0;
      w_ctrl[CTRL_HSYNC] = r_hs2;
      w_ctrl[CTRL_VSYNC] = r_vs2;
   end
   assign vif.pix_req     = w_pix_req;
   assign vif.den         = r_den2;
   assign vif.ctrl_b      = w_ctrl;
   assign vif.data_r      = r_rgb2[23:16];
   assign vif.data_g      = r_rgb2[15:8];
   assign vif.data_b      = r_rgb2[7:0];
   assign vif.h_pos       = r_h2;
   assign vif.v_pos       = r_v2;
   assign vif.frame_start = r_fs2;
endmodule

// File: tb/tb_dvi_tx_video_timing.sv
// tb_dvi_tx_video_timing: randomized check of the timing generator against a frame-position model
module tb_dvi_tx_video_timing;
   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;
   always #5 clk = ~clk;
   dvi_tx_video_timing_if vif();
   dvi_tx_video_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b1)
   ) dut (
      .clock  (clk),
      .reset_n(reset_n),
      .enable (enable),
      .vif    (vif)
   );
   int n_chk = 0;
   int n_fail = 0;
   int s = 0;
   bit pat_frame = 0, pat_d1 = 0, pat_d2 = 0;
   bit rst_nxt = 0, en_nxt = 0, pat_nxt = 0, mode_cnt = 0, req_prev = 0;
   logic [23:0] samp = '0;
   logic [7:0] px_cnt = '0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic bit pat_now();
`ifdef DVI_TX_TEST_PATTERN_EN
      return (s % FT == 0) ? vif.pattern_en : pat_frame;
`else
      return 1'b0;
`endif
   endfunction
   // Model: s counts consecutive enabled edges since the counters were last cleared,
   // so the counter shows position s mod FT and the outputs show position s-2.
   task automatic check_outputs();
      int q, h, v, p;
      bit act;
      logic [23:0] ed;
      q = (s >= 2) ? (s - 2) % FT : -1;
      h = (q >= 0) ? q % HT : 0;
      v = (q >= 0) ? q / HT : 0;
      act = q >= 0 && h < HA && v < VA;
      ed = !act ? 24'h0 : pat_d2 ? bars[h / (HA / 8)] : samp;
      chk("den", 32'(vif.den), 32'(act));
      chk("hsync", 32'(vif.ctrl_b[0]), (q >= 0 && h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
      chk("vsync", 32'(vif.ctrl_b[1]), (q >= 0 && v >= VA + VF && v < VA + VF + VS) ? 1 : 0);
      chk("data", {8'h0, vif.data_r, vif.data_g, vif.data_b}, 32'(ed));
      chk("h_pos", 32'(vif.h_pos), h);
      chk("v_pos", 32'(vif.v_pos), v);
      chk("frame_start", 32'(vif.frame_start), 32'(q == 0));
      if (mode_cnt && act) chk("pix_seq", 32'(vif.data_r), h);
      p = s % FT;
      chk("pix_req", 32'(vif.pix_req),
          32'(reset_n && enable && (p % HT) < HA && (p / HT) < VA && !pat_now()));
   endtask
   task automatic cyc();
      @(posedge clk);
      if (!reset_n) begin
         s = 0;
         pat_frame = 0;
         pat_d1 = 0;
         pat_d2 = 0;
      end else begin
         pat_d2 = pat_d1;
         pat_d1 = pat_now();
`ifdef DVI_TX_TEST_PATTERN_EN
         if (enable && s % FT == 0) pat_frame = vif.pattern_en;
`endif
         s = enable ? s + 1 : 0;
      end
      samp = vif.pix_data;
      #1;
      reset_n = rst_nxt;
      enable = en_nxt;
`ifdef DVI_TX_TEST_PATTERN_EN
      vif.pattern_en = pat_nxt;
`endif
      if (!enable || !reset_n) px_cnt = '0;
      if (mode_cnt && req_prev) begin
         vif.pix_data = {3{px_cnt}};
         px_cnt = 8'((px_cnt + 1) % 8);
      end else
         vif.pix_data = 24'($urandom);
      @(negedge clk);
      check_outputs();
      req_prev = vif.pix_req;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
   initial begin
      bit hit;
      vif.pix_data = '0;
`ifdef DVI_TX_TEST_PATTERN_EN
      vif.pattern_en = 1'b0;
`endif
      for (int i = 0; i < 3; i++) cyc();
      rst_nxt = 1;
      en_nxt = 1;
      mode_cnt = 1;
      for (int i = 0; i < 2 * FT + 20; i++) cyc();
      mode_cnt = 0;
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
         cyc();
         hit = vif.v_pos == 12'd2 && vif.h_pos == 12'd4;
      end
      chk("wait_line2", 32'(hit), 1);
      en_nxt = 0;
      for (int i = 0; i < 3; i++) cyc();
      en_nxt = 1;
      for (int i = 0; i < FT + 10; i++) cyc();
      for (int i = 0; i < 1500; i++) begin
         en_nxt = enable ? ($urandom_range(0, 399) != 0) : ($urandom_range(0, 1) == 1);
`ifdef DVI_TX_TEST_PATTERN_EN
         if ($urandom_range(0, 149) == 0) pat_nxt = !pat_nxt;
`endif
         cyc();
      end
      en_nxt = 1;
`ifdef DVI_TX_TEST_PATTERN_EN
      pat_nxt = 1;
      for (int i = 0; i < 2 * FT + 17; i++) cyc();
      pat_nxt = 0;
      for (int i = 0; i < FT + 40; i++) cyc();
      pat_nxt = 1;
      for (int i = 0; i < 53; i++) cyc();
`endif
      for (int i = 0; i < 50; i++) cyc();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_den", 32'(vif.den), 0);
      chk("rst_ctrl", 32'(vif.ctrl_b), 32'h1);
      chk("rst_data", {8'h0, vif.data_r, vif.data_g, vif.data_b}, 0);
      chk("rst_h_pos", 32'(vif.h_pos), 0);
      chk("rst_v_pos", 32'(vif.v_pos), 0);
      chk("rst_frame_start", 32'(vif.frame_start), 0);
      chk("rst_pix_req", 32'(vif.pix_req), 0);
      rst_nxt = 0;
      for (int i = 0; i < 3; i++) cyc();
      rst_nxt = 1;
      for (int i = 0; i < FT + 30; i++) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
